secuenciador_reduccion: RTL and testbench
=========================================

// Module: secuenciador_reduccion
// PURPOSE
//  Initiator side of the per-pixel interpolator handshake (iniciar/ocupado/listo). Walks the destination
//  image in raster order and derives Q8.8 source coordinates from per-frame scale factors. Fetches the four
//  neighbours from source RAM, launches one interpolation per destination pixel, and writes the result to
//  destination RAM. Sits between the image memories and the sequential-mode bilinear unit.
// PARAMETERS
//  ANCHO_ORIG 128   source width in pixels (>=2)
//  ALTO_ORIG  128   source height in pixels (>=2)
//  ANCHO_DEST 64    destination width in pixels
//  ALTO_DEST  64    destination height in pixels
//  ADDR_W     16    address width of both RAMs (>= clog2 of the larger image)
// PORTS
//  clk             in   1       system clock
//  rst             in   1       synchronous reset, active-high
//  iniciar_cuadro  in   1       pulse: start one frame (ignored unless idle)
//  escala_x        in   16      q8_8_t source step per destination column, sampled at start
//  escala_y        in   16      q8_8_t source step per destination row, sampled at start
//  ocupado         out  1       1 from the cycle after an accepted start until hecho
//  hecho           out  1       1-cycle pulse after the last destination write
//  mem_rd_en       out  1       source RAM read strobe
//  mem_rd_addr     out  ADDR_W  source address = y*ANCHO_ORIG + x
//  mem_rd_data     in   8       source pixel, valid 1 cycle after mem_rd_en
//  int_iniciar     out  1       1-cycle launch pulse to the interpolator
//  int_ocupado     in   1       interpolator busy
//  int_listo       in   1       interpolator ready
//  int_p00/p10/p01/p11  out 8   neighbours (x0,y0),(x1,y0),(x0,y1),(x1,y1)
//  int_fx, int_fy  out  16      q8_8_t fractional weights, {8'h00, frac}
//  int_pixel       in   8       interpolated result
//  mem_wr_en       out  1       destination RAM write strobe
//  mem_wr_addr     out  ADDR_W  destination address = yd*ANCHO_DEST + xd
//  mem_wr_data     out  8       destination pixel
// BEHAVIOUR
//  Reset: all outputs 0; FSM to REPOSO; coordinate accumulators and counters cleared. rst mid-frame aborts
//   the frame on the next edge, with no further RAM writes and no hecho pulse.
//  FSM: REPOSO -> CALC -> R0 -> R1 -> R2 -> R3 -> RC -> LANZA -> ESPERA -> ESCRIBE -> (CALC | FIN) -> REPOSO.
//  REPOSO: on iniciar_cuadro, latch escala_x/y, clear sx, sy, xd, yd, and go to CALC.
//   iniciar_cuadro in any other state is ignored.
//  CALC: x0=sx[int], y0=sy[int], fx=sx[7:0], fy=sy[7:0].
//   If x0 >= ANCHO_ORIG-1, set x0=x1=ANCHO_ORIG-1; otherwise x1=x0+1. Same rule for y on ALTO_ORIG.
//   When clamped, fx (or fy) is forced to 0.
//  R0..R3: one read per cycle, in order 00, 10, 01, 11. R1..RC capture mem_rd_data of the previous read.
//  LANZA: int_iniciar=1 for exactly one cycle; int_p*/fx/fy are held stable from LANZA until ESCRIBE.
//  ESPERA: set visto when int_ocupado=1. Exit when visto && int_listo; int_pixel is sampled in that cycle.
//   No timeout. A stub that holds int_ocupado N cycles extends ESPERA by N.
//  ESCRIBE: mem_wr_en=1 for one cycle with the captured pixel. Then advance:
//   xd++, sx+=escala_x. At xd=ANCHO_DEST-1: xd=0, sx=0, yd++, sy+=escala_y.
//   After the last pixel (xd,yd)=(ANCHO_DEST-1, ALTO_DEST-1) go to FIN.
//  FIN: hecho=1 for one cycle, ocupado falls in the same cycle, then REPOSO. A new start is accepted the next cycle.
//  Accumulators: sx, sy are unsigned, 8 fractional bits and enough integer bits for dest*max scale
//   (8+clog2(ANCHO_DEST)+8). No wrap occurs within a frame.
//  escala=0 is legal: every pixel uses column/row 0.
//  Latency: 10 cycles per destination pixel with a 2-cycle interpolator, i.e. ANCHO_DEST*ALTO_DEST*10 + 2 per frame.
// STRUCTURE
//  formato_pkg: q8_8_t (existing); add estado_sec_t enum and the function frac_a_q(logic [7:0]) -> q8_8_t.
//  Sub-module generador_direcciones: sx/sy accumulators, clamp and address multiply. Combinational outputs
//   registered in CALC.
//  Interpolator is external; int_* connects directly to the sequential-mode unit.
// TESTING
//  4x4 -> 2x2 source, escala 16'h0200, ramp image p=x+4y: reads at addr 0,1,4,5 / 2,3,6,7 ...; writes 0,2,8,10; fx=fy=0.
//  Constant image 8'h80, escala 16'h0180, 8x8 -> 5x5: all 25 writes = 8'h80; hecho once after last write.
//  Right-edge clamp, escala 16'h0180 on width 4: pixel xd=2 has x0=3 -> x1=3, fx=0 -> addresses 3,3,7,7.
//  Interpolator stub holding int_ocupado 5 cycles: exactly one write per launch; int_p*/fx/fy stable during wait.
//  rst asserted mid-ESPERA, then iniciar_cuadro: no write from the aborted pixel; new frame restarts at addr 0.
//  iniciar_cuadro pulsed while ocupado=1: ignored; write count stays ANCHO_DEST*ALTO_DEST; escala unchanged.

Source files
------------

// File: rtl/formato_pkg.sv
// Shared fixed-point format and the sequencer state encoding for the downscaling path.
package formato_pkg;

    typedef logic [15:0] q8_8_t;

    typedef enum logic [3:0] {
        REPOSO, CALC, R0, R1, R2, R3, RC, LANZA, ESPERA, ESCRIBE, FIN
    } estado_sec_t;

    function automatic q8_8_t frac_a_q(input logic [7:0] frac);
        return {8'h00, frac};
    endfunction

endpackage

// File: rtl/generador_direcciones.sv
// Source-coordinate accumulators, edge clamp and both RAM address products.
// Outputs are combinational from the current accumulators; the sequencer samples them in CALC.
module generador_direcciones
    import formato_pkg::*;
#(
    parameter int ANCHO_ORIG = 128,
    parameter int ALTO_ORIG  = 128,
    parameter int ANCHO_DEST = 64,
    parameter int ALTO_DEST  = 64,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              carga_i,
    input  logic              avanza_i,
    input  q8_8_t             escala_x_i,
    input  q8_8_t             escala_y_i,
    output logic [ADDR_W-1:0] a00_o,
    output logic [ADDR_W-1:0] a10_o,
    output logic [ADDR_W-1:0] a01_o,
    output logic [ADDR_W-1:0] a11_o,
    output logic [7:0]        fx_o,
    output logic [7:0]        fy_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              ultimo_o
);
    localparam int AX_W = 16 + $clog2(ANCHO_DEST);
    localparam int AY_W = 16 + $clog2(ALTO_DEST);
    localparam int XD_W = $clog2(ANCHO_DEST + 1);
    localparam int YD_W = $clog2(ALTO_DEST + 1);
    localparam logic [XD_W-1:0]   XD_ULT = XD_W'(ANCHO_DEST - 1);
    localparam logic [YD_W-1:0]   YD_ULT = YD_W'(ALTO_DEST - 1);
    localparam logic [ADDR_W-1:0] W_ORIG = ADDR_W'(ANCHO_ORIG);
    localparam logic [ADDR_W-1:0] W_DEST = ADDR_W'(ANCHO_DEST);

    q8_8_t            esc_x_q, esc_y_q;
    logic [AX_W-1:0]  sx_q;
    logic [AY_W-1:0]  sy_q;
    logic [XD_W-1:0]  xd_q;
    logic [YD_W-1:0]  yd_q;
    logic [ADDR_W-1:0] x0, x1, y0, y1;

    always_ff @(posedge clk) begin
        if (rst || carga_i) begin
            esc_x_q <= rst ? '0 : escala_x_i;
            esc_y_q <= rst ? '0 : escala_y_i;
            sx_q    <= '0;
            sy_q    <= '0;
            xd_q    <= '0;
            yd_q    <= '0;
        end else if (avanza_i) begin
            // End of a row restarts the column accumulator rather than subtracting.
            if (xd_q == XD_ULT) begin
                xd_q <= '0;
                sx_q <= '0;
                yd_q <= yd_q + 1'b1;
                sy_q <= sy_q + AY_W'(esc_y_q);
            end else begin
                xd_q <= xd_q + 1'b1;
                sx_q <= sx_q + AX_W'(esc_x_q);
            end
        end
    end

    always_comb begin
        x0   = ADDR_W'(sx_q[AX_W-1:8]);
        x1   = x0 + 1'b1;
        fx_o = sx_q[7:0];
        if (32'(sx_q[AX_W-1:8]) >= ANCHO_ORIG - 1) begin
            x0   = ADDR_W'(ANCHO_ORIG - 1);
            x1   = x0;
            fx_o = 8'h00;
        end
        y0   = ADDR_W'(sy_q[AY_W-1:8]);
        y1   = y0 + 1'b1;
        fy_o = sy_q[7:0];
        if (32'(sy_q[AY_W-1:8]) >= ALTO_ORIG - 1) begin
            y0   = ADDR_W'(ALTO_ORIG - 1);
            y1   = y0;
            fy_o = 8'h00;
        end
    end

    assign a00_o     = y0 * W_ORIG + x0;
    assign a10_o     = y0 * W_ORIG + x1;
    assign a01_o     = y1 * W_ORIG + x0;
    assign a11_o     = y1 * W_ORIG + x1;
    assign wr_addr_o = ADDR_W'(yd_q) * W_DEST + ADDR_W'(xd_q);
    assign ultimo_o  = (xd_q == XD_ULT) && (yd_q == YD_ULT);

endmodule

// File: rtl/secuenciador_reduccion.sv
// Raster-order frame sequencer: fetches four neighbours per destination pixel, runs one
// interpolation, writes the result. All outputs come straight from registers.
module secuenciador_reduccion
    import formato_pkg::*;
#(
    parameter int ANCHO_ORIG = 128,
    parameter int ALTO_ORIG  = 128,
    parameter int ANCHO_DEST = 64,
    parameter int ALTO_DEST  = 64,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iniciar_cuadro,
    input  q8_8_t             escala_x,
    input  q8_8_t             escala_y,
    output logic              ocupado,
    output logic              hecho,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              int_iniciar,
    input  logic              int_ocupado,
    input  logic              int_listo,
    output logic [7:0]        int_p00,
    output logic [7:0]        int_p10,
    output logic [7:0]        int_p01,
    output logic [7:0]        int_p11,
    output q8_8_t             int_fx,
    output q8_8_t             int_fy,
    input  logic [7:0]        int_pixel,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [7:0]        mem_wr_data,
    output estado_sec_t       estado_dbg
);
    estado_sec_t       estado_q;
    logic              ocupado_q, hecho_q, rd_en_q, iniciar_q, wr_en_q, visto_q;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q, a10_q, a01_q, a11_q;
    logic [7:0]        p00_q, p10_q, p01_q, p11_q, wr_data_q;
    q8_8_t             fx_q, fy_q;
    logic [ADDR_W-1:0] a00, a10, a01, a11, dest_addr;
    logic [7:0]        fx, fy;
    logic              ultimo;

    generador_direcciones #(
        .ANCHO_ORIG(ANCHO_ORIG), .ALTO_ORIG(ALTO_ORIG),
        .ANCHO_DEST(ANCHO_DEST), .ALTO_DEST(ALTO_DEST), .ADDR_W(ADDR_W)
    ) u_gen (
        .clk       (clk),
        .rst       (rst),
        .carga_i   (estado_q == REPOSO && iniciar_cuadro),
        .avanza_i  (estado_q == ESCRIBE),
        .escala_x_i(escala_x),
        .escala_y_i(escala_y),
        .a00_o     (a00),
        .a10_o     (a10),
        .a01_o     (a01),
        .a11_o     (a11),
        .fx_o      (fx),
        .fy_o      (fy),
        .wr_addr_o (dest_addr),
        .ultimo_o  (ultimo)
    );

    // Interpolator handshake: int_iniciar pulses once per pixel. The result is accepted on
    // int_listo only after int_ocupado has been seen, so a stale int_listo is never taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= REPOSO;
            ocupado_q <= 1'b0;
            hecho_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            iniciar_q <= 1'b0;
            wr_en_q   <= 1'b0;
            visto_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            a10_q     <= '0;
            a01_q     <= '0;
            a11_q     <= '0;
            p00_q     <= '0;
            p10_q     <= '0;
            p01_q     <= '0;
            p11_q     <= '0;
            wr_data_q <= '0;
            fx_q      <= '0;
            fy_q      <= '0;
        end else begin
            iniciar_q <= 1'b0;
            wr_en_q   <= 1'b0;
            hecho_q   <= 1'b0;
            case (estado_q)
                REPOSO: if (iniciar_cuadro) begin
                    ocupado_q <= 1'b1;
                    estado_q  <= CALC;
                end
                CALC: begin
                    fx_q      <= frac_a_q(fx);
                    fy_q      <= frac_a_q(fy);
                    a10_q     <= a10;
                    a01_q     <= a01;
                    a11_q     <= a11;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= a00;
                    estado_q  <= R0;
                end
                R0: begin
                    rd_addr_q <= a10_q;
                    estado_q  <= R1;
                end
                R1: begin
                    p00_q     <= mem_rd_data;
                    rd_addr_q <= a01_q;
                    estado_q  <= R2;
                end
                R2: begin
                    p10_q     <= mem_rd_data;
                    rd_addr_q <= a11_q;
                    estado_q  <= R3;
                end
                R3: begin
                    p01_q    <= mem_rd_data;
                    rd_en_q  <= 1'b0;
                    estado_q <= RC;
                end
                RC: begin
                    p11_q     <= mem_rd_data;
                    iniciar_q <= 1'b1;
                    visto_q   <= 1'b0;
                    estado_q  <= LANZA;
                end
                LANZA: estado_q <= ESPERA;
                ESPERA: begin
                    if (int_ocupado) visto_q <= 1'b1;
                    if (visto_q && int_listo) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= int_pixel;
                        wr_addr_q <= dest_addr;
                        estado_q  <= ESCRIBE;
                    end
                end
                ESCRIBE: if (ultimo) begin
                    ocupado_q <= 1'b0;
                    hecho_q   <= 1'b1;
                    estado_q  <= FIN;
                end else begin
                    estado_q <= CALC;
                end
                FIN:     estado_q <= REPOSO;
                default: estado_q <= REPOSO;
            endcase
        end
    end

    assign ocupado     = ocupado_q;
    assign hecho       = hecho_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign int_iniciar = iniciar_q;
    assign int_p00     = p00_q;
    assign int_p10     = p10_q;
    assign int_p01     = p01_q;
    assign int_p11     = p11_q;
    assign int_fx      = fx_q;
    assign int_fy      = fy_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign estado_dbg  = estado_q;

endmodule

// File: tb/tb_secuenciador_reduccion.sv
// Bench for secuenciador_reduccion: source RAM and interpolator stub around the DUT, a
// coordinate reference model feeding expected queues, and a negedge scoreboard.
module tb_secuenciador_reduccion;
    import formato_pkg::*;

    localparam int AO = 6;
    localparam int HO = 5;
    localparam int AD = 4;
    localparam int HD = 3;
    localparam int AW = 16;
    localparam int NPIX = AD * HD;
    localparam int PRESUPUESTO = 2000;

    logic          clk, rst, iniciar_cuadro;
    q8_8_t         escala_x, escala_y;
    logic          ocupado, hecho, mem_rd_en, int_iniciar, int_ocupado, int_listo, mem_wr_en;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [7:0]    mem_rd_data, int_p00, int_p10, int_p01, int_p11, int_pixel, mem_wr_data;
    q8_8_t         int_fx, int_fy;
    estado_sec_t   estado_dbg;

    logic [7:0]  ram [AO*HO];
    logic [15:0] exp_rd_q[$];
    logic [63:0] exp_lz_q[$];
    logic [23:0] exp_wr_q[$];
    int          n_checks = 0, n_pass = 0;
    int          wr_total = 0, hecho_total = 0;
    int          stub_hold = 1, stub_cnt = 0;
    logic        en_espera = 1'b0;
    logic [63:0] lanz, lanz_ref;

    secuenciador_reduccion #(
        .ANCHO_ORIG(AO), .ALTO_ORIG(HO), .ANCHO_DEST(AD), .ALTO_DEST(HD), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .iniciar_cuadro(iniciar_cuadro),
        .escala_x(escala_x), .escala_y(escala_y),
        .ocupado(ocupado), .hecho(hecho),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .int_iniciar(int_iniciar), .int_ocupado(int_ocupado), .int_listo(int_listo),
        .int_p00(int_p00), .int_p10(int_p10), .int_p01(int_p01), .int_p11(int_p11),
        .int_fx(int_fx), .int_fy(int_fy), .int_pixel(int_pixel),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .estado_dbg(estado_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in interpolator result: any fixed mix of the inputs that the model can recompute.
    function automatic logic [7:0] mezcla(input logic [7:0] a, b, c, d, f, g);
        return 8'(a + 3 * b + 5 * c + 7 * d + f + 2 * g);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_cond(input string tag, input logic cond);
        n_checks++;
        assert (cond === 1'b1) n_pass++;
        else $error("FAIL %s: condition observed %b expected 1", tag, cond);
    endtask

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

    always @(posedge clk) begin
        if (rst) begin
            int_ocupado <= 1'b0;
            int_listo   <= 1'b0;
            int_pixel   <= 8'h00;
            stub_cnt    <= 0;
        end else begin
            int_listo <= 1'b0;
            if (int_iniciar) begin
                int_ocupado <= 1'b1;
                stub_cnt    <= stub_hold - 1;
                int_pixel   <= mezcla(int_p00, int_p10, int_p01, int_p11, int_fx[7:0], int_fy[7:0]);
            end else if (int_ocupado) begin
                if (stub_cnt == 0) begin
                    int_ocupado <= 1'b0;
                    int_listo   <= 1'b1;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    // Reference: every destination pixel computed directly as xd*escala, independent of history.
    task automatic modelo(input logic [15:0] ex, input logic [15:0] ey);
        int sx, sy, x0, x1, y0, y1, fx, fy;
        logic [7:0] p00, p10, p01, p11;
        for (int yd = 0; yd < HD; yd++) begin
            for (int xd = 0; xd < AD; xd++) begin
                sx = xd * int'(ex);
                sy = yd * int'(ey);
                x0 = sx / 256; fx = sx % 256;
                y0 = sy / 256; fy = sy % 256;
                if (x0 >= AO - 1) begin x0 = AO - 1; x1 = x0; fx = 0; end else x1 = x0 + 1;
                if (y0 >= HO - 1) begin y0 = HO - 1; y1 = y0; fy = 0; end else y1 = y0 + 1;
                p00 = ram[y0*AO+x0]; p10 = ram[y0*AO+x1];
                p01 = ram[y1*AO+x0]; p11 = ram[y1*AO+x1];
                exp_rd_q.push_back(16'(y0*AO+x0));
                exp_rd_q.push_back(16'(y0*AO+x1));
                exp_rd_q.push_back(16'(y1*AO+x0));
                exp_rd_q.push_back(16'(y1*AO+x1));
                exp_lz_q.push_back({p00, p10, p01, p11, 16'(fx), 16'(fy)});
                exp_wr_q.push_back({16'(yd*AD+xd), mezcla(p00, p10, p01, p11, 8'(fx), 8'(fy))});
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            en_espera = 1'b0;
        end else begin
            if (mem_rd_en) begin
                check_cond("rd_esperada", exp_rd_q.size() != 0);
                if (exp_rd_q.size() != 0) check("rd_addr", 64'(mem_rd_addr), 64'(exp_rd_q.pop_front()));
            end
            lanz = {int_p00, int_p10, int_p01, int_p11, int_fx, int_fy};
            if (int_iniciar) begin
                check_cond("lanz_esperado", exp_lz_q.size() != 0);
                if (exp_lz_q.size() != 0) check("lanzamiento", lanz, exp_lz_q.pop_front());
                lanz_ref  = lanz;
                en_espera = 1'b1;
            end else if (en_espera) begin
                check("estable_en_espera", lanz, lanz_ref);
            end
            if (mem_wr_en) begin
                check_cond("wr_esperada", exp_wr_q.size() != 0);
                if (exp_wr_q.size() != 0) check("escritura", 64'({mem_wr_addr, mem_wr_data}), 64'(exp_wr_q.pop_front()));
                wr_total++;
                en_espera = 1'b0;
            end
            if (hecho) hecho_total++;
        end
    end

    task automatic llenar(input int modo);
        for (int i = 0; i < AO * HO; i++)
            ram[i] = (modo == 0) ? 8'(i) : (modo == 1) ? 8'h80 : 8'($urandom);
    endtask

    task automatic arrancar(input logic [15:0] ex, input logic [15:0] ey);
        @(negedge clk);
        iniciar_cuadro = 1'b1;
        escala_x = ex;
        escala_y = ey;
        @(negedge clk);
        iniciar_cuadro = 1'b0;
        check("ocupado_tras_inicio", 64'(ocupado), 64'd1);
        escala_x = ~ex;
        escala_y = ~ey;
    endtask

    task automatic cuadro(input logic [15:0] ex, input logic [15:0] ey, input int hold,
                          input int modo, input bit tocar);
        int cyc, base_wr, base_hecho;
        llenar(modo);
        stub_hold = hold;
        modelo(ex, ey);
        base_wr = wr_total;
        base_hecho = hecho_total;
        arrancar(ex, ey);
        cyc = 1;
        while (!hecho && cyc < PRESUPUESTO) begin
            iniciar_cuadro = tocar && (cyc == 25);
            @(negedge clk);
            cyc++;
        end
        iniciar_cuadro = 1'b0;
        check_cond("hecho_a_tiempo", hecho);
        check("ocupado_en_hecho", 64'(ocupado), 64'd0);
        check("ciclos_cuadro", 64'(cyc + 1), 64'(NPIX * (9 + hold) + 2));
        repeat (3) @(negedge clk);
        check("hecho_fin", 64'(hecho), 64'd0);
        check("escrituras", 64'(wr_total - base_wr), 64'(NPIX));
        check("pulsos_hecho", 64'(hecho_total - base_hecho), 64'd1);
        check("colas_vacias", 64'(exp_rd_q.size() + exp_lz_q.size() + exp_wr_q.size()), 64'd0);
    endtask

    task automatic revisar_reset(input string tag);
        check({tag, "_ctl"}, 64'({ocupado, hecho, mem_rd_en, int_iniciar, mem_wr_en,
                                  mem_rd_addr, mem_wr_addr, mem_wr_data}), 64'd0);
        check({tag, "_datos"}, {int_p00, int_p10, int_p01, int_p11, int_fx, int_fy}, 64'd0);
        check({tag, "_estado"}, 64'(estado_dbg), 64'(REPOSO));
    endtask

    initial begin
        int cyc, base_wr, base_hecho;
        rst = 1'b1;
        iniciar_cuadro = 1'b0;
        escala_x = '0;
        escala_y = '0;
        repeat (3) @(negedge clk);
        revisar_reset("reset_inicial");
        rst = 1'b0;
        @(negedge clk);

        cuadro(16'h0200, 16'h0200, 1, 0, 1'b0);
        cuadro(16'h0180, 16'h0180, 1, 1, 1'b0);
        cuadro(16'h0180, 16'h0100, 5, 2, 1'b1);
        cuadro(16'h0000, 16'h0000, 1, 2, 1'b0);

        // Abort in the middle of a long interpolator wait.
        llenar(2);
        stub_hold = 5;
        modelo(16'h0100, 16'h0100);
        arrancar(16'h0100, 16'h0100);
        cyc = 0;
        while (!(wr_total > 0 && int_ocupado && estado_dbg == ESPERA) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check_cond("espera_para_reset", cyc < 500);
        rst = 1'b1;
        @(negedge clk);
        revisar_reset("reset_en_espera");
        exp_rd_q.delete();
        exp_lz_q.delete();
        exp_wr_q.delete();
        rst = 1'b0;
        base_wr = wr_total;
        base_hecho = hecho_total;
        repeat (20) @(negedge clk);
        check("sin_escritura_abortada", 64'(wr_total - base_wr), 64'd0);
        check("sin_hecho_abortado", 64'(hecho_total - base_hecho), 64'd0);
        cuadro(16'h0100, 16'h0100, 1, 0, 1'b0);

        for (int k = 0; k < 4; k++)
            cuadro(16'($urandom_range(0, 16'h0300)), 16'($urandom_range(0, 16'h0300)),
                   $urandom_range(1, 3), 2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
